cc_level_sequencer: RTL and testbench
=====================================

// Module: cc_level_sequencer
// PURPOSE
//  Upstream sequencer for CC_LEVEL_DATAHANDLER. Generates CurrentLvl and LvlProgress, which the
//  handler maps to 8-bit lane data. Advances LvlProgress on a divided game-tick.
//  The division ratio is set per level; higher levels scroll faster.
//  On frog-goal it moves to the next level; on frog-death it restarts the level; after the last level it latches a win.
// PARAMETERS
//  CURRENTLEVEL_DATAWIDTH   3   width of CurrentLvl output (matches handler)
//  LEVELPROGRESS_DATAWIDTH  5   width of LvlProgress output (matches handler)
//  PROGRESS_MAX             12  last progress value; counter range 1..PROGRESS_MAX
//  LEVEL_MAX                3   last playable level; levels run 1..LEVEL_MAX
//  PRESCALER_WIDTH          4   width of step prescaler
//  TICKDIV_LVL1             8   Step_In pulses per progress advance, level 1
//  TICKDIV_LVL2             6   same, level 2
//  TICKDIV_LVL3             4   same, level 3 (and any level >3)
// PORTS
//  CC_LEVEL_SEQUENCER_CLOCK_50              in   1  system clock, rising edge
//  CC_LEVEL_SEQUENCER_RESET_InLow           in   1  asynchronous, active-low reset
//  CC_LEVEL_SEQUENCER_Start_In              in   1  1-cycle pulse: start/restart game
//  CC_LEVEL_SEQUENCER_Pause_In              in   1  level: high freezes progress advance
//  CC_LEVEL_SEQUENCER_Step_In               in   1  1-cycle game tick from timer block
//  CC_LEVEL_SEQUENCER_FrogGoal_In           in   1  1-cycle pulse: frog reached top row
//  CC_LEVEL_SEQUENCER_FrogDeath_In          in   1  1-cycle pulse: frog collided
//  CC_LEVEL_SEQUENCER_CurrentLvl_OutBus     out  3  level to handler; 0 = blank/idle
//  CC_LEVEL_SEQUENCER_LvlProgress_OutBus    out  5  progress to handler; 0 = blank
//  CC_LEVEL_SEQUENCER_Running_Out           out  1  high while state==RUN
//  CC_LEVEL_SEQUENCER_LevelDone_Out         out  1  1-cycle pulse on level completion
//  CC_LEVEL_SEQUENCER_GameWin_Out           out  1  high while state==WIN
// BEHAVIOUR
//  - All outputs are registered. Reset (async, RESET_InLow=0) forces:
//    state=IDLE, CurrentLvl=0, LvlProgress=0, prescaler=0, Running=0, LevelDone=0, GameWin=0.
//  - FSM states: IDLE, RUN, LVL_DONE, WIN.
//  - IDLE: Start -> RUN, CurrentLvl=1, LvlProgress=1, prescaler=0. Other inputs are ignored.
//  - RUN, input priority: FrogDeath > FrogGoal > Step. Start is ignored.
//    FrogDeath: LvlProgress=1, prescaler=0, level unchanged, stay in RUN.
//    FrogGoal: -> LVL_DONE; progress and prescaler hold.
//    Step & !Pause: if prescaler==DIV(lvl)-1, then prescaler=0 and progress advances,
//      else prescaler+=1.
//      Progress advance: PROGRESS_MAX wraps to 1, otherwise +1. Progress never takes 0 or PROGRESS_MAX+1.
//    Step & Pause: no change (prescaler holds, not cleared).
//  - LVL_DONE: lasts exactly 1 cycle. LevelDone_Out=1 for that cycle only.
//    If CurrentLvl==LEVEL_MAX: -> WIN; Lvl and Progress hold.
//    Otherwise: -> RUN, CurrentLvl+=1, LvlProgress=1, prescaler=0.
//    All inputs in this cycle are ignored.
//  - WIN: GameWin_Out=1; Lvl and Progress frozen. Start -> RUN, Lvl=1, Progress=1, prescaler=0,
//    GameWin drops the same edge.
//  - DIV(lvl) is selected from CurrentLvl: 1->LVL1, 2->LVL2, >=3->LVL3.
//    The prescaler compares against the DIV of the level currently held.
//  - Latency: input sampled at edge N is reflected on the outputs after edge N.
//    Goal-to-next-level takes 2 edges (LVL_DONE, then RUN).
//  - Running_Out = (state==RUN), registered alongside the state.
// TESTING
//  1 Reset mid-RUN (lvl2, prog7): assert RESET_InLow=0 asynchronously.
//    -> all outputs 0 immediately; state IDLE.
//  2 Start, then 8 Steps at lvl1 -> LvlProgress goes 1->2 on the 8th Step only.
//    96 Steps return it to 1 (wrap at 12).
//  3 Lvl1, prog 5, FrogGoal -> LevelDone=1 for 1 cycle, then Lvl=2, Prog=1.
//    Next advance after 6 Steps.
//  4 Pause=1 with 20 Steps -> progress and prescaler unchanged.
//    Release, then 1 Step completes a previously half-filled prescale.
//  5 FrogDeath and FrogGoal in the same cycle at lvl2, prog9 -> Prog=1, Lvl=2, no LevelDone.
//  6 Goal on lvl3 -> LevelDone pulse, then GameWin=1 with Lvl=3 held.
//    Steps are ignored; Start -> Lvl=1, Prog=1, GameWin=0.

Source files
------------

// File: rtl/cc_level_sequencer.sv
// cc_level_sequencer: level/progress sequencer feeding the CC level data handler.
// Progress advances once every DIV(level) game ticks, wraps 12 -> 1, and the
// level steps forward on each goal until the last level latches a win.
module cc_level_sequencer #(
  parameter int CURRENTLEVEL_DATAWIDTH  = 3,
  parameter int LEVELPROGRESS_DATAWIDTH = 5,
  parameter int PROGRESS_MAX            = 12,
  parameter int LEVEL_MAX               = 3,
  parameter int PRESCALER_WIDTH         = 4,
  parameter int TICKDIV_LVL1            = 8,
  parameter int TICKDIV_LVL2            = 6,
  parameter int TICKDIV_LVL3            = 4
) (
  input  logic                               CC_LEVEL_SEQUENCER_CLOCK_50,
  input  logic                               CC_LEVEL_SEQUENCER_RESET_InLow,
  input  logic                               CC_LEVEL_SEQUENCER_Start_In,
  input  logic                               CC_LEVEL_SEQUENCER_Pause_In,
  input  logic                               CC_LEVEL_SEQUENCER_Step_In,
  input  logic                               CC_LEVEL_SEQUENCER_FrogGoal_In,
  input  logic                               CC_LEVEL_SEQUENCER_FrogDeath_In,
  output logic [CURRENTLEVEL_DATAWIDTH-1:0]  CC_LEVEL_SEQUENCER_CurrentLvl_OutBus,
  output logic [LEVELPROGRESS_DATAWIDTH-1:0] CC_LEVEL_SEQUENCER_LvlProgress_OutBus,
  output logic                               CC_LEVEL_SEQUENCER_Running_Out,
  output logic                               CC_LEVEL_SEQUENCER_LevelDone_Out,
  output logic                               CC_LEVEL_SEQUENCER_GameWin_Out
);

  localparam int LW = CURRENTLEVEL_DATAWIDTH;
  localparam int PW = LEVELPROGRESS_DATAWIDTH;
  localparam int SW = PRESCALER_WIDTH;

  localparam logic [LW-1:0] LVL_FIRST = LW'(1);
  localparam logic [LW-1:0] LVL_TWO   = LW'(2);
  localparam logic [LW-1:0] LVL_LAST  = LW'(LEVEL_MAX);
  localparam logic [PW-1:0] PROG_ONE  = PW'(1);
  localparam logic [PW-1:0] PROG_LAST = PW'(PROGRESS_MAX);
  localparam logic [SW-1:0] LAST_TICK_L1 = SW'(TICKDIV_LVL1 - 1);
  localparam logic [SW-1:0] LAST_TICK_L2 = SW'(TICKDIV_LVL2 - 1);
  localparam logic [SW-1:0] LAST_TICK_L3 = SW'(TICKDIV_LVL3 - 1);

  typedef enum logic [1:0] {IDLE, RUN, LVL_DONE, WIN} state_t;

  state_t        state;
  logic [LW-1:0] lvl;
  logic [PW-1:0] prog;
  logic [SW-1:0] prescaler;
  logic [SW-1:0] last_tick;
  logic          running;
  logic          level_done;
  logic          game_win;

  assign CC_LEVEL_SEQUENCER_CurrentLvl_OutBus  = lvl;
  assign CC_LEVEL_SEQUENCER_LvlProgress_OutBus = prog;
  assign CC_LEVEL_SEQUENCER_Running_Out        = running;
  assign CC_LEVEL_SEQUENCER_LevelDone_Out      = level_done;
  assign CC_LEVEL_SEQUENCER_GameWin_Out        = game_win;

  // Terminal prescaler count for the level currently held; level 3 and above share the fastest rate.
  always_comb begin
    last_tick = LAST_TICK_L3;
    if (lvl == LVL_FIRST) begin
      last_tick = LAST_TICK_L1;
    end else if (lvl == LVL_TWO) begin
      last_tick = LAST_TICK_L2;
    end
  end

  // Game FSM with all outputs registered alongside the state.
  always_ff @(posedge CC_LEVEL_SEQUENCER_CLOCK_50 or negedge CC_LEVEL_SEQUENCER_RESET_InLow) begin
    if (!CC_LEVEL_SEQUENCER_RESET_InLow) begin
      state      <= IDLE;
      lvl        <= '0;
      prog       <= '0;
      prescaler  <= '0;
      running    <= 1'b0;
      level_done <= 1'b0;
      game_win   <= 1'b0;
    end else begin
      level_done <= 1'b0;
      case (state)
        IDLE: begin
          if (CC_LEVEL_SEQUENCER_Start_In) begin
            state     <= RUN;
            lvl       <= LVL_FIRST;
            prog      <= PROG_ONE;
            prescaler <= '0;
            running   <= 1'b1;
          end
        end
        RUN: begin
          if (CC_LEVEL_SEQUENCER_FrogDeath_In) begin
            prog      <= PROG_ONE;
            prescaler <= '0;
          end else if (CC_LEVEL_SEQUENCER_FrogGoal_In) begin
            state      <= LVL_DONE;
            running    <= 1'b0;
            level_done <= 1'b1;
          end else if (CC_LEVEL_SEQUENCER_Step_In && !CC_LEVEL_SEQUENCER_Pause_In) begin
            if (prescaler == last_tick) begin
              prescaler <= '0;
              prog      <= (prog == PROG_LAST) ? PROG_ONE : prog + PROG_ONE;
            end else begin
              prescaler <= prescaler + SW'(1);
            end
          end
        end
        LVL_DONE: begin
          if (lvl == LVL_LAST) begin
            state    <= WIN;
            game_win <= 1'b1;
          end else begin
            state     <= RUN;
            running   <= 1'b1;
            lvl       <= lvl + LW'(1);
            prog      <= PROG_ONE;
            prescaler <= '0;
          end
        end
        WIN: begin
          if (CC_LEVEL_SEQUENCER_Start_In) begin
            state     <= RUN;
            game_win  <= 1'b0;
            running   <= 1'b1;
            lvl       <= LVL_FIRST;
            prog      <= PROG_ONE;
            prescaler <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cc_level_sequencer.sv
// tb_cc_level_sequencer: vector table, hand-written corner sequences and
// randomized stimulus against a behavioural game model.
module tb_cc_level_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start, pause, step, goal, death;
  logic [2:0] cur_lvl;
  logic [4:0] lvl_prog;
  logic       running, level_done, game_win;

  int vectors;
  int miscompares;

  // Behavioural model of the game: playing / celebrating a finished level / won.
  bit m_play, m_cel, m_won;
  int m_lvl, m_prog, m_ticks;

  typedef struct {
    bit s, p, st, g, d;
    int lvl, prog;
    bit run, done, win;
  } vec_t;

  vec_t tbl[$];

  cc_level_sequencer dut (
    .CC_LEVEL_SEQUENCER_CLOCK_50           (clk),
    .CC_LEVEL_SEQUENCER_RESET_InLow        (rst_n),
    .CC_LEVEL_SEQUENCER_Start_In           (start),
    .CC_LEVEL_SEQUENCER_Pause_In           (pause),
    .CC_LEVEL_SEQUENCER_Step_In            (step),
    .CC_LEVEL_SEQUENCER_FrogGoal_In        (goal),
    .CC_LEVEL_SEQUENCER_FrogDeath_In       (death),
    .CC_LEVEL_SEQUENCER_CurrentLvl_OutBus  (cur_lvl),
    .CC_LEVEL_SEQUENCER_LvlProgress_OutBus (lvl_prog),
    .CC_LEVEL_SEQUENCER_Running_Out        (running),
    .CC_LEVEL_SEQUENCER_LevelDone_Out      (level_done),
    .CC_LEVEL_SEQUENCER_GameWin_Out        (game_win)
  );

  // 50 MHz-style free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(bit s, bit p, bit st, bit g, bit d,
                              int lvl, int prog, bit run, bit done, bit win);
    vec_t v;
    v.s = s; v.p = p; v.st = st; v.g = g; v.d = d;
    v.lvl = lvl; v.prog = prog; v.run = run; v.done = done; v.win = win;
    return v;
  endfunction

  function automatic int tick_div(int lvl);
    if (lvl == 1) return 8;
    if (lvl == 2) return 6;
    return 4;
  endfunction

  function automatic void model_reset();
    m_play = 0; m_cel = 0; m_won = 0;
    m_lvl = 0; m_prog = 0; m_ticks = 0;
  endfunction

  function automatic void model_restart_level(int lvl);
    m_play = 1; m_lvl = lvl; m_prog = 1; m_ticks = 0;
  endfunction

  function automatic void model_step(bit s, bit p, bit st, bit g, bit d);
    if (m_cel) begin
      m_cel = 0;
      if (m_lvl == 3) m_won = 1;
      else model_restart_level(m_lvl + 1);
    end else if (m_won) begin
      if (s) begin
        m_won = 0;
        model_restart_level(1);
      end
    end else if (!m_play) begin
      if (s) model_restart_level(1);
    end else if (d) begin
      m_prog = 1;
      m_ticks = 0;
    end else if (g) begin
      m_play = 0;
      m_cel = 1;
    end else if (st && !p) begin
      m_ticks++;
      if (m_ticks == tick_div(m_lvl)) begin
        m_ticks = 0;
        m_prog = (m_prog % 12) + 1;
      end
    end
  endfunction

  // Drive one cycle of inputs, let the edge take them, then return 1 ns after the edge.
  task automatic applyStimulus(bit s, bit p, bit st, bit g, bit d);
    start = s; pause = p; step = st; goal = g; death = d;
    model_step(s, p, st, g, d);
    @(posedge clk);
    #1;
    start = 0; pause = 0; step = 0; goal = 0; death = 0;
  endtask

  task automatic checkOutput(string name, int lvl, int prog, bit run, bit done, bit win);
    vectors++;
    if (cur_lvl !== 3'(lvl) || lvl_prog !== 5'(prog) || running !== run ||
        level_done !== done || game_win !== win) begin
      miscompares++;
      $display("[TB] FAIL %s: got lvl=%0d prog=%0d run=%b done=%b win=%b, want lvl=%0d prog=%0d run=%b done=%b win=%b",
               name, cur_lvl, lvl_prog, running, level_done, game_win, lvl, prog, run, done, win);
    end
  endtask

  task automatic checkModel(string name);
    checkOutput(name, m_lvl, m_prog, m_play, m_cel, m_won);
  endtask

  // Asynchronous reset pulse placed mid-cycle, checked before any clock edge arrives.
  task automatic pulseReset(string name);
    #2 rst_n = 0;
    #1;
    model_reset();
    checkOutput(name, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic stepN(int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 1, 0, 0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    start = 0; pause = 0; step = 0; goal = 0; death = 0;
    model_reset();
    rst_n = 0;
    #12 rst_n = 1;
    @(posedge clk);
    #1;

    // Vector table: inputs for one cycle and the outputs expected after that edge.
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,1,1,1, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0, 1,1,1,0,0));
    for (int i = 0; i < 7; i++) tbl.push_back(mk(0,0,1,0,0, 1,1,1,0,0));
    tbl.push_back(mk(0,0,1,0,0, 1,2,1,0,0));
    tbl.push_back(mk(0,1,1,0,0, 1,2,1,0,0));
    tbl.push_back(mk(0,0,0,1,0, 1,2,0,1,0));
    tbl.push_back(mk(1,0,1,1,1, 2,1,1,0,0));
    tbl.push_back(mk(0,0,1,0,0, 2,1,1,0,0));
    tbl.push_back(mk(0,0,0,1,1, 2,1,1,0,0));
    tbl.push_back(mk(1,0,0,0,0, 2,1,1,0,0));
    tbl.push_back(mk(0,0,0,1,0, 2,1,0,1,0));
    tbl.push_back(mk(0,0,0,0,0, 3,1,1,0,0));
    tbl.push_back(mk(0,0,1,0,0, 3,1,1,0,0));
    tbl.push_back(mk(0,0,0,1,0, 3,1,0,1,0));
    tbl.push_back(mk(1,0,1,0,0, 3,1,0,0,1));
    tbl.push_back(mk(0,0,1,0,0, 3,1,0,0,1));
    tbl.push_back(mk(0,0,0,1,1, 3,1,0,0,1));
    tbl.push_back(mk(1,0,0,0,0, 1,1,1,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].s, tbl[i].p, tbl[i].st, tbl[i].g, tbl[i].d);
      checkOutput($sformatf("table[%0d]", i), tbl[i].lvl, tbl[i].prog,
                  tbl[i].run, tbl[i].done, tbl[i].win);
    end

    // Wrap: 95 steps at level 1 reach 12, the 96th returns to 1.
    pulseReset("reset_before_wrap");
    applyStimulus(1, 0, 0, 0, 0);
    stepN(95);
    checkOutput("wrap_95", 1, 12, 1, 0, 0);
    stepN(1);
    checkOutput("wrap_96", 1, 1, 1, 0, 0);

    // Pause holds a half-filled prescale; one step after release completes it.
    stepN(7);
    checkOutput("pre_pause", 1, 1, 1, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, 1, 0, 0);
    checkOutput("paused", 1, 1, 1, 0, 0);
    stepN(1);
    checkOutput("pause_release", 1, 2, 1, 0, 0);

    // Goal from level 1 progress 5, then level 2 advances after 6 steps.
    pulseReset("reset_before_goal");
    applyStimulus(1, 0, 0, 0, 0);
    stepN(32);
    checkOutput("lvl1_prog5", 1, 5, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("goal_done", 1, 5, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("lvl2_entry", 2, 1, 1, 0, 0);
    stepN(5);
    checkOutput("lvl2_5steps", 2, 1, 1, 0, 0);
    stepN(1);
    checkOutput("lvl2_6steps", 2, 2, 1, 0, 0);

    // Reset mid-run at level 2 progress 7, then idle ignores steps.
    stepN(30);
    checkOutput("lvl2_prog7", 2, 7, 1, 0, 0);
    pulseReset("async_reset_midrun");
    applyStimulus(0, 0, 1, 1, 1);
    checkOutput("idle_after_reset", 0, 0, 0, 0, 0);

    // Randomized play against the behavioural model.
    applyStimulus(1, 0, 0, 0, 0);
    checkModel("rand_start");
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        pulseReset($sformatf("rand_reset[%0d]", i));
      end else begin
        applyStimulus($urandom_range(0, 24) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0,
                      $urandom_range(0, 59) == 0);
        checkModel($sformatf("rand[%0d]", i));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
